// File: rtl/sram_port_arbiter_if.sv
// rtl/sram_port_arbiter_if.sv - requester, response and SRAM-side signal bundle for sram_port_arbiter
//
// Purpose: groups the core port, ext port and sram0 signals of the arbiter.
//   slave  : arbiter view (requests and sram_rdata in; grants, returns, SRAM drive out)
//   master : environment view (requesters plus the SRAM itself)
// Signals:
//   core_req/we/addr/wdata, ext_req/we/addr/wdata : access requests
//   core_gnt, core_stall, ext_gnt                 : grant / MEM-stage stall
//   core_rvalid/rdata, ext_rvalid/rdata           : read return
//   sram_en/we/addr/wdata, sram_rdata             : single-port SRAM interface
interface sram_port_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
);
    logic              core_req;
    logic              core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic              core_gnt;
    logic              core_stall;
    logic              core_rvalid;
    logic [DATA_W-1:0] core_rdata;

    logic              ext_req;
    logic              ext_we;
    logic [ADDR_W-1:0] ext_addr;
    logic [DATA_W-1:0] ext_wdata;
    logic              ext_gnt;
    logic              ext_rvalid;
    logic [DATA_W-1:0] ext_rdata;

    logic              sram_en;
    logic              sram_we;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        input  ext_req, ext_we, ext_addr, ext_wdata,
        input  sram_rdata,
        output core_gnt, core_stall, core_rvalid, core_rdata,
        output ext_gnt, ext_rvalid, ext_rdata,
        output sram_en, sram_we, sram_addr, sram_wdata
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata,
        output ext_req, ext_we, ext_addr, ext_wdata,
        output sram_rdata,
        input  core_gnt, core_stall, core_rvalid, core_rdata,
        input  ext_gnt, ext_rvalid, ext_rdata,
        input  sram_en, sram_we, sram_addr, sram_wdata
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - core/ext arbiter for the single-port data SRAM with starvation guard
//
// Purpose: shares sram0 between the core load/store port and the ext
//   (debug/DMA preload) port. Core has priority; ext is force-granted after
//   STARVE_MAX consecutive denied cycles. Read data returns one cycle after
//   grant to the port that issued the read and is held there afterwards.
// Ports:
//   clk  : clock, rising edge
//   rstn : asynchronous active-low reset
//   bus  : sram_port_arbiter_if.slave (requests, grants, read return, SRAM drive)
module sram_port_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 10,
    parameter int STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    sram_port_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_EXT  = 2'd2
    } owner_e;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0]        starve_cnt_q, starve_cnt_d;
    owner_e            rd_owner_q, rd_owner_d;
    logic [DATA_W-1:0] core_rdata_q, core_rdata_d;
    logic [DATA_W-1:0] ext_rdata_q, ext_rdata_d;

    logic              force_grant;
    logic              core_gnt;
    logic              ext_gnt;
    logic              core_rvalid;
    logic              ext_rvalid;
    logic              sram_we_c;
    logic [ADDR_W-1:0] sram_addr_c;
    logic [DATA_W-1:0] sram_wdata_c;

    // Grants are qualified with rstn so nothing reaches the SRAM while in reset.
    assign force_grant = (starve_cnt_q == STARVE_LIM);
    assign ext_gnt     = rstn & bus.ext_req & (force_grant | ~bus.core_req);
    assign core_gnt    = rstn & bus.core_req & ~ext_gnt;

    // Read return is a decode of the registered owner, so rvalid is one cycle after grant.
    assign core_rvalid = (rd_owner_q == OWN_CORE);
    assign ext_rvalid  = (rd_owner_q == OWN_EXT);

    always_comb begin
        sram_we_c    = 1'b0;
        sram_addr_c  = '0;
        sram_wdata_c = '0;
        if (core_gnt) begin
            sram_we_c    = bus.core_we;
            sram_addr_c  = bus.core_addr;
            sram_wdata_c = bus.core_wdata;
        end else if (ext_gnt) begin
            sram_we_c    = bus.ext_we;
            sram_addr_c  = bus.ext_addr;
            sram_wdata_c = bus.ext_wdata;
        end
    end

    always_comb begin
        // Saturating count of consecutive denied ext cycles; any grant or idle cycle clears it.
        starve_cnt_d = 4'd0;
        if (bus.ext_req && !ext_gnt) begin
            starve_cnt_d = force_grant ? starve_cnt_q : starve_cnt_q + 4'd1;
        end

        rd_owner_d = OWN_NONE;
        if (core_gnt && !bus.core_we) begin
            rd_owner_d = OWN_CORE;
        end else if (ext_gnt && !bus.ext_we) begin
            rd_owner_d = OWN_EXT;
        end

        core_rdata_d = core_rvalid ? bus.sram_rdata : core_rdata_q;
        ext_rdata_d  = ext_rvalid  ? bus.sram_rdata : ext_rdata_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            starve_cnt_q <= 4'd0;
            rd_owner_q   <= OWN_NONE;
            core_rdata_q <= '0;
            ext_rdata_q  <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            rd_owner_q   <= rd_owner_d;
            core_rdata_q <= core_rdata_d;
            ext_rdata_q  <= ext_rdata_d;
        end
    end

    assign bus.core_gnt    = core_gnt;
    assign bus.ext_gnt     = ext_gnt;
    assign bus.core_stall  = bus.core_req & ~core_gnt;
    assign bus.core_rvalid = core_rvalid;
    assign bus.ext_rvalid  = ext_rvalid;
    // SRAM data is passed through during the rvalid cycle; the register holds it after.
    assign bus.core_rdata  = core_rvalid ? bus.sram_rdata : core_rdata_q;
    assign bus.ext_rdata   = ext_rvalid  ? bus.sram_rdata : ext_rdata_q;
    assign bus.sram_en     = core_gnt | ext_gnt;
    assign bus.sram_we     = sram_we_c;
    assign bus.sram_addr   = sram_addr_c;
    assign bus.sram_wdata  = sram_wdata_c;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - self-checking bench for sram_port_arbiter
module tb_sram_port_arbiter;
    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 10;
    localparam int STARVE_MAX = 4;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    sram_port_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    sram_port_arbiter #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus.slave)
    );

    // sram0 model: synchronous read, write on sram_en & sram_we.
    logic [31:0] mem [0:1023];
    always @(posedge clk) begin
        if (bus.sram_en) begin
            if (bus.sram_we) mem[bus.sram_addr] <= bus.sram_wdata;
            else             bus.sram_rdata     <= mem[bus.sram_addr];
        end
    end

    typedef struct {
        logic        cr, cw;
        logic [9:0]  ca;
        logic [31:0] cd;
        logic        er, ew;
        logic [9:0]  ea;
        logic [31:0] ed;
        logic        gc, ge;
        logic [31:0] rd;
    } vec_t;

    typedef struct {
        logic [1:0]  owner;
        logic [31:0] data;
    } exp_t;

    vec_t vecs[$];
    vec_t vecs2[$];
    exp_t sb[$];
    int errors = 0;
    int checks = 0;
    logic [31:0] hold_c, hold_e;

    function automatic vec_t mk(logic cr, logic cw, logic [9:0] ca, logic [31:0] cd,
                                logic er, logic ew, logic [9:0] ea, logic [31:0] ed,
                                logic gc, logic ge, logic [31:0] rd);
        vec_t v;
        v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
        v.er = er; v.ew = ew; v.ea = ea; v.ed = ed;
        v.gc = gc; v.ge = ge; v.rd = rd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.core_req   = v.cr; bus.core_we = v.cw; bus.core_addr = v.ca; bus.core_wdata = v.cd;
        bus.ext_req    = v.er; bus.ext_we  = v.ew; bus.ext_addr  = v.ea; bus.ext_wdata  = v.ed;
    endtask

    task automatic check_return(input string tag);
        exp_t e;
        if (sb.size() > 0) e = sb.pop_front();
        else begin e.owner = 2'd0; e.data = 32'd0; end
        chk({tag, " core_rvalid"}, 32'(bus.core_rvalid), 32'(e.owner == 2'd1));
        chk({tag, " ext_rvalid"},  32'(bus.ext_rvalid),  32'(e.owner == 2'd2));
        if (e.owner == 2'd1) hold_c = e.data;
        if (e.owner == 2'd2) hold_e = e.data;
        chk({tag, " core_rdata"}, bus.core_rdata, hold_c);
        chk({tag, " ext_rdata"},  bus.ext_rdata,  hold_e);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        exp_t e;
        logic [9:0]  ea;
        logic [31:0] ewd;
        logic        ewe;
        @(negedge clk);
        drive(v);
        #2;
        ewe = v.gc ? v.cw : (v.ge ? v.ew : 1'b0);
        ea  = v.gc ? v.ca : (v.ge ? v.ea : 10'd0);
        ewd = v.gc ? v.cd : (v.ge ? v.ed : 32'd0);
        chk({tag, " core_gnt"},   32'(bus.core_gnt),   32'(v.gc));
        chk({tag, " ext_gnt"},    32'(bus.ext_gnt),    32'(v.ge));
        chk({tag, " core_stall"}, 32'(bus.core_stall), 32'(v.cr & ~v.gc));
        chk({tag, " sram_en"},    32'(bus.sram_en),    32'(v.gc | v.ge));
        chk({tag, " sram_we"},    32'(bus.sram_we),    32'(ewe));
        chk({tag, " sram_addr"},  32'(bus.sram_addr),  32'(ea));
        chk({tag, " sram_wdata"}, bus.sram_wdata,      ewd);
        check_return(tag);
        e.owner = (v.gc && !v.cw) ? 2'd1 : ((v.ge && !v.ew) ? 2'd2 : 2'd0);
        e.data  = v.rd;
        sb.push_back(e);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        mem[600] = 32'h8000_0000;
        mem[1]   = 32'd10;
        mem[2]   = 32'd20;
        hold_c = 32'd0;
        hold_e = 32'd0;

        // reset state with live requests
        rstn = 1'b0;
        drive(mk(H, L, 10'd600, 32'd0, H, L, 10'd2, 32'd0, L, L, 32'd0));
        for (int k = 0; k < 2; k++) begin
            #3;
            chk("rst core_gnt",    32'(bus.core_gnt),    32'd0);
            chk("rst ext_gnt",     32'(bus.ext_gnt),     32'd0);
            chk("rst sram_en",     32'(bus.sram_en),     32'd0);
            chk("rst sram_we",     32'(bus.sram_we),     32'd0);
            chk("rst core_rvalid", 32'(bus.core_rvalid), 32'd0);
            chk("rst ext_rvalid",  32'(bus.ext_rvalid),  32'd0);
            chk("rst core_rdata",  bus.core_rdata,       32'd0);
            chk("rst ext_rdata",   bus.ext_rdata,        32'd0);
            @(posedge clk);
        end
        @(negedge clk);
        drive(mk(L, L, 10'd0, 32'd0, L, L, 10'd0, 32'd0, L, L, 32'd0));
        rstn = 1'b1;

        // core read 600, hold
        vecs.push_back(mk(H, L, 10'd600, 32'd0, L, L, 10'd0, 32'd0, H, L, 32'h8000_0000));
        vecs.push_back(mk(L, L, 10'd0, 32'd0, L, L, 10'd0, 32'd0, L, L, 32'd0));
        vecs.push_back(mk(L, L, 10'd0, 32'd0, L, L, 10'd0, 32'd0, L, L, 32'd0));
        // core write 200 then read back
        vecs.push_back(mk(H, H, 10'd200, 32'd7, L, L, 10'd0, 32'd0, H, L, 32'd0));
        vecs.push_back(mk(H, L, 10'd200, 32'd0, L, L, 10'd0, 32'd0, H, L, 32'd7));
        vecs.push_back(mk(L, L, 10'd0, 32'd0, L, L, 10'd0, 32'd0, L, L, 32'd0));
        // starvation: 4 denied, forced in 5th cycle
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(H, H, 10'(300 + i), 32'(32'hA0 + i), H, L, 10'd600, 32'd0, H, L, 32'd0));
        vecs.push_back(mk(H, H, 10'd304, 32'hA4, H, L, 10'd600, 32'd0, L, H, 32'h8000_0000));
        // counter restarted from 0: another 4 core cycles before the next force
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(H, H, 10'(304 + i), 32'(32'hA4 + i), H, L, 10'd600, 32'd0, H, L, 32'd0));
        vecs.push_back(mk(H, H, 10'd308, 32'hA8, H, L, 10'd600, 32'd0, L, H, 32'h8000_0000));
        // ext_req drop while starved clears the count
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(H, H, 10'(308 + i), 32'(32'hA8 + i), H, L, 10'd600, 32'd0, H, L, 32'd0));
        vecs.push_back(mk(H, H, 10'd311, 32'hAB, L, L, 10'd600, 32'd0, H, L, 32'd0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(H, H, 10'(312 + i), 32'(32'hAC + i), H, L, 10'd600, 32'd0, H, L, 32'd0));
        vecs.push_back(mk(H, H, 10'd316, 32'hB0, H, L, 10'd600, 32'd0, L, H, 32'h8000_0000));
        // interleaved return: core reads 1, ext forced read of 2
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(H, H, 10'(316 + i), 32'(32'hB0 + i), H, L, 10'd2, 32'd0, H, L, 32'd0));
        vecs.push_back(mk(H, L, 10'd1, 32'd0, H, L, 10'd2, 32'd0, H, L, 32'd10));
        vecs.push_back(mk(H, L, 10'd1, 32'd0, H, L, 10'd2, 32'd0, L, H, 32'd20));
        vecs.push_back(mk(H, L, 10'd1, 32'd0, L, L, 10'd0, 32'd0, H, L, 32'd10));
        vecs.push_back(mk(L, L, 10'd0, 32'd0, L, L, 10'd0, 32'd0, L, L, 32'd0));
        vecs.push_back(mk(L, L, 10'd0, 32'd0, L, L, 10'd0, 32'd0, L, L, 32'd0));

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("v%0d", i));

        // reset asserted between a read grant and its return
        sb.delete();
        @(negedge clk);
        drive(mk(H, L, 10'd1, 32'd0, L, L, 10'd0, 32'd0, L, L, 32'd0));
        #2;
        chk("midrst core_gnt", 32'(bus.core_gnt), 32'd1);
        #1;
        rstn = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst core_rvalid in reset", 32'(bus.core_rvalid), 32'd0);
        @(negedge clk);
        drive(mk(L, L, 10'd0, 32'd0, L, L, 10'd0, 32'd0, L, L, 32'd0));
        rstn = 1'b1;
        hold_c = 32'd0;
        hold_e = 32'd0;
        vecs2.push_back(mk(L, L, 10'd0, 32'd0, L, L, 10'd0, 32'd0, L, L, 32'd0));
        vecs2.push_back(mk(H, L, 10'd600, 32'd0, L, L, 10'd0, 32'd0, H, L, 32'h8000_0000));
        vecs2.push_back(mk(L, L, 10'd0, 32'd0, L, L, 10'd0, 32'd0, L, L, 32'd0));
        vecs2.push_back(mk(L, L, 10'd0, 32'd0, L, L, 10'd0, 32'd0, L, L, 32'd0));
        foreach (vecs2[i]) run_vec(vecs2[i], $sformatf("post_rst%0d", i));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
